// File: rtl/frame_writer_bram.sv
// rtl/frame_writer_bram.sv - RGB888 pixel stream to RGB565 linear frame-BRAM writer
module frame_writer_bram #(
   parameter int FRAME_PIXELS = 76800,
   parameter int ADDR_WIDTH   = 17,
   parameter bit CONTINUOUS   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   input  logic                  in_sof_i,
   input  logic [23:0]           in_data_i,
   input  logic                  capture_req_i,
   output logic                  bram_we_o,
   output logic [ADDR_WIDTH-1:0] bram_addr_o,
   output logic [15:0]           bram_din_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic                  sof_err_o,
   output logic [7:0]            frame_count_o
);

   // ADDR_WIDTH must be wide enough that FRAME_PIXELS-1 is representable.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
   localparam bit                    SINGLE_PIXEL_FRAME = (FRAME_PIXELS == 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_WRITE    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           din_q, din_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [7:0]            cnt_q, cnt_d;

   // Truncating RGB888 -> RGB565 pack of the incoming pixel.
   logic [15:0] pixel_565;
   assign pixel_565 = {in_data_i[23:19], in_data_i[15:10], in_data_i[7:3]};

   // Next-state and registered-output decode; every pixel write is staged one cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (CONTINUOUS || capture_req_i) begin
               state_d = ST_WAIT_SOF;
            end
         end

         ST_WAIT_SOF: begin
            // Pixels before the frame start are discarded.
            if (in_valid_i && in_sof_i) begin
               we_d   = 1'b1;
               addr_d = ZERO_ADDR;
               din_d  = pixel_565;
               if (SINGLE_PIXEL_FRAME) begin
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
                  ptr_d   = ZERO_ADDR;
                  state_d = ST_DONE;
               end else begin
                  ptr_d   = ONE_ADDR;
                  state_d = ST_WRITE;
               end
            end
         end

         ST_WRITE: begin
            if (in_valid_i) begin
               we_d  = 1'b1;
               din_d = pixel_565;
               if (in_sof_i && (ptr_q != ZERO_ADDR)) begin
                  // Early frame start: drop the partial frame and resync at address 0.
                  err_d  = 1'b1;
                  addr_d = ZERO_ADDR;
                  ptr_d  = ONE_ADDR;
               end else if (ptr_q == LAST_ADDR) begin
                  addr_d  = ptr_q;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
                  ptr_d   = ZERO_ADDR;
                  state_d = ST_DONE;
               end else begin
                  addr_d = ptr_q;
                  ptr_d  = ptr_q + ONE_ADDR;
               end
            end
         end

         ST_DONE: begin
            // One dead cycle; any pixel here is dropped.
            state_d = CONTINUOUS ? ST_WAIT_SOF : ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, pointer and output registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bram_we_o     = we_q;
   assign bram_addr_o   = addr_q;
   assign bram_din_o    = din_q;
   assign busy_o        = busy_q;
   assign frame_done_o  = done_q;
   assign sof_err_o     = err_q;
   assign frame_count_o = cnt_q;

endmodule

// File: doc/frame_writer_bram.md
Name: frame_writer_bram

Overview:
- Upstream neighbour of the VGA frame-buffer reader: takes an RGB888 pixel stream from the imaging pipeline, packs it to RGB565 and writes it linearly into the 320x240 frame BRAM (write port, addresses 0..FRAME_PIXELS-1).
- The reader scans the same BRAM on its read port.
- Supports continuous capture or single-frame snapshot, frame-start alignment, short-frame recovery and a frame counter.

Parameters:
- FRAME_PIXELS, 76800, pixels per frame (320x240); last address = FRAME_PIXELS-1.
- ADDR_WIDTH, 17, BRAM address width; must satisfy 2^ADDR_WIDTH >= FRAME_PIXELS.
- CONTINUOUS, 1, 1 = re-arm automatically after every frame; 0 = capture one frame per capture_req.

Ports:
- clk  in  1  pixel/system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel qualifier; one pixel per cycle when high.
- in_sof  in  1  first pixel of frame; meaningful only with in_valid.
- in_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- capture_req  in  1  snapshot request, level-sampled; used only when CONTINUOUS=0.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_din  out  16  RGB565 write data {R5, G6, B5}.
- busy  out  1  high in WAIT_SOF, WRITE and DONE.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written.
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.
- frame_count  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal write pointer 0.
- Packing: bram_din = {in_data[23:19], in_data[15:10], in_data[7:3]}; truncation only, no rounding.
- Latency: a pixel accepted at edge n appears on bram_we/addr/din at edge n+1. All outputs are registered.
- bram_we is high only in the cycle following an accepted pixel; addr/din hold their last value when bram_we=0.
- State machine (IDLE, WAIT_SOF, WRITE, DONE):
  - IDLE: if CONTINUOUS=1, go to WAIT_SOF next cycle. Otherwise go to WAIT_SOF on capture_req=1. Pixels are ignored.
  - WAIT_SOF: in_valid without in_sof is dropped. in_valid&in_sof writes the pixel at addr 0, sets pointer=1 and moves to WRITE. If FRAME_PIXELS=1, it moves directly to DONE.
  - WRITE: each in_valid writes at pointer and increments pointer. in_valid=0 stalls with no write.
  - WRITE, last pixel: the pixel written at FRAME_PIXELS-1 moves to DONE. Pointer resets to 0. frame_done pulses together with that pixel's bram_we. frame_count increments in the same cycle.
  - WRITE, mid-frame SOF: in_valid&in_sof at pointer != 0 pulses sof_err. That pixel is written at addr 0, pointer=1, and the state stays WRITE. The partial frame is abandoned and frame_count is unchanged.
  - DONE: lasts 1 cycle, then goes to WAIT_SOF (CONTINUOUS=1) or IDLE (CONTINUOUS=0). A pixel arriving in DONE is dropped, even with in_sof.
- capture_req is ignored outside IDLE; it need not be held.
- Pointer never exceeds FRAME_PIXELS-1. No BRAM write occurs at addresses >= FRAME_PIXELS.
- Reset asserted mid-frame: everything returns to reset values immediately. A frame in progress is lost and the next frame must start with in_sof.
- busy=0 only in IDLE, so in continuous mode busy stays 1 from one cycle after reset.

Test Plan (bench uses FRAME_PIXELS=16, ADDR_WIDTH=5 unless noted):
- Continuous clean frame: 16 valid pixels, first with in_sof, data 24'hF8FC00 ... -> 16 writes at addr 0..15, din[0]=16'hFFE0. frame_done pulses with the addr-15 write. frame_count=1. Next frame repeats from addr 0.
- Pre-SOF garbage and stalls: 5 pixels without sof, then a frame with in_valid toggling 1,0,1 -> the first 5 are dropped (no bram_we). Addresses stay contiguous across the gaps with no writes during gaps.
- Short frame: sof, 7 pixels, then sof again plus 16 pixels -> sof_err pulses once. Address restarts at 0 on the second sof. frame_done pulses once and frame_count=1.
- Snapshot mode (CONTINUOUS=0): stream runs constantly; pulse capture_req once -> exactly one frame (16 writes) after the next sof, then busy=0 and no further writes until another capture_req.
- Reset mid-frame: assert rst_n=0 after the pixel at addr 9 -> bram_we, frame_done, busy and frame_count go to 0 asynchronously. After release, pixels without sof produce no writes.
- Full size: FRAME_PIXELS=76800, ADDR_WIDTH=17 -> last write at addr 17'd76799. frame_done is coincident with it and the next write is at 0.
